// File: rtl/plot_port_arbiter_if.sv
// Bundles the two requester ports, the draw-engine port and the status outputs of plot_port_arbiter.
// The master modport is the requester/engine side; the slave modport is the arbiter itself.
interface plot_port_arbiter_if #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
);
    logic             req0;
    logic             req1;
    logic [X_W-1:0]   x0;
    logic [X_W-1:0]   x1;
    logic [Y_W-1:0]   y0;
    logic [Y_W-1:0]   y1;
    logic [SEL_W-1:0] sel0;
    logic [SEL_W-1:0] sel1;
    logic             ack0;
    logic             ack1;
    logic             done0;
    logic             done1;
    logic [X_W-1:0]   plot_x;
    logic [Y_W-1:0]   plot_y;
    logic [SEL_W-1:0] plot_select;
    logic             plot_start;
    logic             plot_done;
    logic             busy;
    logic             owner;
    logic [CNT_W-1:0] draw_count;
    logic             timeout_err;

    modport master (
        output req0, req1, x0, x1, y0, y1, sel0, sel1, plot_done,
        input  ack0, ack1, done0, done1, plot_x, plot_y, plot_select, plot_start,
               busy, owner, draw_count, timeout_err
    );

    modport slave (
        input  req0, req1, x0, x1, y0, y1, sel0, sel1, plot_done,
        output ack0, ack1, done0, done1, plot_x, plot_y, plot_select, plot_start,
               busy, owner, draw_count, timeout_err
    );
endinterface

// File: rtl/plot_port_arbiter.sv
// Round-robin share of the plot engine between two cell-draw requesters; PLOT_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: req at edge k -> ack + plot_start in cycle k+1; done pulse one cycle after plot_done is sampled.
// Backpressure: requesters hold req until ack; the engine stays owned until plot_done (or the watchdog fires).
module plot_port_arbiter #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
`ifdef PLOT_ARB_TIMEOUT_EN
    , parameter int TIMEOUT = 4096
`endif
) (
    input logic                clock,
    input logic                reset,
    plot_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic             start_q, start_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant;

`ifdef PLOT_ARB_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT + 1);
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             terr_q, terr_d;
`endif

    // On a tie the grant goes to whoever did not own the previous one.
    assign grant = (bus.req0 && bus.req1) ? ~owner_q : bus.req1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        start_d = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        cnt_d   = cnt_q;
`ifdef PLOT_ARB_TIMEOUT_EN
        wcnt_d  = wcnt_q;
        terr_d  = terr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    owner_d = grant;
                    x_d     = grant ? bus.x1   : bus.x0;
                    y_d     = grant ? bus.y1   : bus.y0;
                    sel_d   = grant ? bus.sel1 : bus.sel0;
                    ack0_d  = ~grant;
                    ack1_d  = grant;
                    start_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef PLOT_ARB_TIMEOUT_EN
                wcnt_d  = '0;
`endif
            end
            WAIT: begin
                if (bus.plot_done) begin
                    state_d = IDLE;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
`ifdef PLOT_ARB_TIMEOUT_EN
                // Abandon the draw without counting it; the owner still sees done so it can retry.
                else if (wcnt_q == WC_W'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    terr_d  = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + WC_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef PLOT_ARB_TIMEOUT_EN
            wcnt_q  <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            start_q <= start_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
`ifdef PLOT_ARB_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.done0       = done0_q;
    assign bus.done1       = done1_q;
    assign bus.plot_x      = x_q;
    assign bus.plot_y      = y_q;
    assign bus.plot_select = sel_q;
    assign bus.plot_start  = start_q;
    assign bus.busy        = busy_q;
    assign bus.owner       = owner_q;
    assign bus.draw_count  = cnt_q;
`ifdef PLOT_ARB_TIMEOUT_EN
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_plot_port_arbiter.sv
// Directed and randomized bench for plot_port_arbiter against a transaction-timing reference model.
module tb_plot_port_arbiter;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;
`ifdef PLOT_ARB_TIMEOUT_EN
    localparam int TO    = 16;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    plot_port_arbiter_if #(.X_W(X_W), .Y_W(Y_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    plot_port_arbiter #(
        .X_W(X_W), .Y_W(Y_W), .SEL_W(SEL_W), .CNT_W(CNT_W)
`ifdef PLOT_ARB_TIMEOUT_EN
        , .TIMEOUT(TO)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each grant is a transaction with known edge numbers.
    int n, g_edge, done_edge, next_free, m_count;
    bit m_owner, m_timed, m_terr;
    logic [X_W-1:0]   m_x;
    logic [Y_W-1:0]   m_y;
    logic [SEL_W-1:0] m_sel;
    bit rnd_mode, hold_mode, spur;
    int fixed_delay;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; g_edge = -100; done_edge = -100; next_free = 1; m_count = 0;
        m_owner = 1'b1; m_timed = 1'b0; m_terr = 1'b0;
        m_x = '0; m_y = '0; m_sel = '0;
    endtask

    task automatic check_all();
        chk("ack0",        32'(bus.ack0),        32'(n == g_edge && !m_owner));
        chk("ack1",        32'(bus.ack1),        32'(n == g_edge && m_owner));
        chk("plot_start",  32'(bus.plot_start),  32'(n == g_edge));
        chk("done0",       32'(bus.done0),       32'(n == done_edge && !m_owner));
        chk("done1",       32'(bus.done1),       32'(n == done_edge && m_owner));
        chk("busy",        32'(bus.busy),        32'(n >= g_edge && n < done_edge));
        chk("owner",       32'(bus.owner),       32'(m_owner));
        chk("plot_x",      32'(bus.plot_x),      32'(m_x));
        chk("plot_y",      32'(bus.plot_y),      32'(m_y));
        chk("plot_select", 32'(bus.plot_select), 32'(m_sel));
        chk("draw_count",  32'(bus.draw_count),  32'(m_count));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.plot_done = 1'b0; spur = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock: drive engine/arbitration inputs for the coming edge, predict, sample, then act as requesters.
    task automatic cycle();
        int e;
        int d;
        e = n + 1;
        bus.plot_done = ((e == done_edge) && !m_timed) ||
                        (spur && !(e >= g_edge + 2 && e <= done_edge));
        if ((bus.req0 || bus.req1) && e >= next_free) begin
            m_owner = (bus.req0 && bus.req1) ? !m_owner : bus.req1;
            m_x   = m_owner ? bus.x1   : bus.x0;
            m_y   = m_owner ? bus.y1   : bus.y0;
            m_sel = m_owner ? bus.sel1 : bus.sel0;
            d = rnd_mode ? int'($urandom_range(1, 6)) : fixed_delay;
            g_edge = e;
            m_timed = 1'b0;
            done_edge = e + 1 + d;
`ifdef PLOT_ARB_TIMEOUT_EN
            if (d > TO) begin
                m_timed = 1'b1;
                done_edge = e + 1 + TO;
            end
`endif
            next_free = done_edge + 1;
        end
        @(posedge clock);
        #1;
        n = e;
        if (n == done_edge) begin
            if (m_timed) m_terr = 1'b1;
            else         m_count = (m_count + 1) % (1 << CNT_W);
        end
        check_all();
        if (n == g_edge && !hold_mode) begin
            if (m_owner) bus.req1 = 1'b0;
            else         bus.req0 = 1'b0;
        end
        if (!bus.req0) begin
            bus.x0 = X_W'($urandom); bus.y0 = Y_W'($urandom); bus.sel0 = SEL_W'($urandom);
            if (rnd_mode && $urandom_range(0, 2) == 0) bus.req0 = 1'b1;
        end
        if (!bus.req1) begin
            bus.x1 = X_W'($urandom); bus.y1 = Y_W'($urandom); bus.sel1 = SEL_W'($urandom);
            if (rnd_mode && $urandom_range(0, 2) == 0) bus.req1 = 1'b1;
        end
        if (rnd_mode) spur = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        bit found;
        int gcyc, dones, gcount, overlap, wraps, prev_cnt, cnt_before;
        logic [3:0] gseq;
        bus.x0 = '0; bus.x1 = '0; bus.y0 = '0; bus.y1 = '0; bus.sel0 = '0; bus.sel1 = '0;
        rnd_mode = 1'b0; hold_mode = 1'b0; fixed_delay = 3;
        do_reset();
        check_all();

        // Single request with fixed data, completion 10 cycles into WAIT.
        bus.x0 = 8'd40; bus.y0 = 7'd20; bus.sel0 = 2'd2; bus.req0 = 1'b1; fixed_delay = 10;
        cycle();
        gcyc = n;
        chk("t2_ack0", 32'(bus.ack0), 32'd1);
        chk("t2_start", 32'(bus.plot_start), 32'd1);
        chk("t2_plot_x", 32'(bus.plot_x), 32'd40);
        chk("t2_plot_y", 32'(bus.plot_y), 32'd20);
        chk("t2_select", 32'(bus.plot_select), 32'd2);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            cycle();
            if (bus.done0) begin
                found = 1'b1;
                chk("t2_done_latency", 32'(n - gcyc), 32'd11);
            end
        end
        chk("t2_done_seen", 32'(found), 32'd1);
        chk("t2_count", 32'(bus.draw_count), 32'd1);

        // plot_done asserted in IDLE and ISSUE must be ignored.
        spur = 1'b1; dones = 0;
        repeat (3) begin
            cycle();
            dones += int'(bus.done0) + int'(bus.done1);
        end
        chk("t4_idle_count", 32'(bus.draw_count), 32'd1);
        bus.x1 = 8'd7; bus.req1 = 1'b1; fixed_delay = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            dones += int'(bus.done0) + int'(bus.done1);
            if (bus.done1) found = 1'b1;
        end
        spur = 1'b0;
        chk("t4_done_pulses", 32'(dones), 32'd1);
        chk("t4_count", 32'(bus.draw_count), 32'd2);

        // Both requesters held high: grants must alternate starting with req0.
        do_reset();
        hold_mode = 1'b1; fixed_delay = 5; bus.req0 = 1'b1; bus.req1 = 1'b1;
        gcount = 0; overlap = 0; gseq = '0;
        for (int i = 0; i < 80 && gcount < 4; i++) begin
            cycle();
            if (bus.ack0 && bus.ack1) overlap++;
            if (bus.ack0 || bus.ack1) begin
                gseq[gcount] = bus.ack1;
                gcount++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; hold_mode = 1'b0;
        chk("t3_grants", 32'(gcount), 32'd4);
        chk("t3_sequence", 32'(gseq), 32'b1010);
        chk("t3_overlap", 32'(overlap), 32'd0);
        for (int i = 0; i < 20 && bus.busy; i++) cycle();
        chk("t3_drained", 32'(bus.busy), 32'd0);

        // Asynchronous reset while the engine is mid-draw.
        bus.req0 = 1'b1; fixed_delay = 1000000;
        repeat (3) cycle();
        chk("t1_pre_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1; bus.req0 = 1'b0;
        #2;
        chk("t1_async_busy", 32'(bus.busy), 32'd0);
        chk("t1_async_x", 32'(bus.plot_x), 32'd0);
        chk("t1_async_count", 32'(bus.draw_count), 32'd0);
        chk("t1_async_owner", 32'(bus.owner), 32'd1);
        @(posedge clock);
        #1;
        chk("t1_next_busy", 32'(bus.busy), 32'd0);
        chk("t1_next_start", 32'(bus.plot_start), 32'd0);
        chk("t1_next_sel", 32'(bus.plot_select), 32'd0);
        do_reset();
        repeat (3) cycle();

`ifdef PLOT_ARB_TIMEOUT_EN
        // Watchdog: no plot_done at all.
        cnt_before = int'(bus.draw_count);
        bus.req0 = 1'b1; fixed_delay = 1000000; gcyc = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (bus.ack0) gcyc = n;
            if (bus.done0) begin
                found = 1'b1;
                chk("t5_to_latency", 32'(n - gcyc), 32'(TO + 1));
            end
        end
        chk("t5_done_seen", 32'(found), 32'd1);
        chk("t5_terr", 32'(bus.timeout_err), 32'd1);
        chk("t5_count", 32'(bus.draw_count), 32'(cnt_before));
        bus.req1 = 1'b1; fixed_delay = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (bus.done1) found = 1'b1;
        end
        chk("t5_next_grant", 32'(found), 32'd1);
`else
        cnt_before = int'(bus.draw_count);
        chk("t5_terr_tied", 32'(bus.timeout_err), 32'd0);
        chk("t5_count_idle", 32'(cnt_before), 32'd0);
`endif

        // Randomized traffic, long enough for the draw counter to wrap.
        do_reset();
        rnd_mode = 1'b1; wraps = 0; prev_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            cycle();
            if (prev_cnt == (1 << CNT_W) - 1 && bus.draw_count == '0) wraps++;
            prev_cnt = int'(bus.draw_count);
        end
        rnd_mode = 1'b0;
        chk("t6_wrapped", 32'(wraps > 0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
